alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_mul_iter.sv | 59 +++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, controller states and the
// flag bundle that travels with every result.
package alu_pkg;

   // Operation codes. Values 11..15 are unused and take the illegal path.
   typedef enum logic [3:0] {
      OP_PASS = 4'd0,
      OP_ADD  = 4'd1,
      OP_AND  = 4'd2,
      OP_NOT  = 4'd3,
      OP_SUB  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_SHL  = 4'd7,
      OP_SHR  = 4'd8,
      OP_SRA  = 4'd9,
      OP_MUL  = 4'd10
   } alu_op_t;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } alu_state_t;

   // Result flags; n/z/p describe the signed value of the result.
   typedef struct packed {
      logic n;
      logic z;
      logic p;
      logic c;
      logic v;
      logic err;
   } alu_flags_t;

   // Flags matching a zero result, used out of reset.
   localparam alu_flags_t FLAGS_RESET = '{n: 1'b0, z: 1'b1, p: 1'b0,
                                          c: 1'b0, v: 1'b0, err: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// A start pulse loads the operands; one multiplier bit is consumed per
// cycle. done is asserted combinationally during the cycle that folds in the
// last bit, with product already holding the final value, so the caller can
// register the result on the WIDTH-th edge after the start edge.
module alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             busy;
   logic [WIDTH-1:0] step;

   // Partial sum including the current multiplier bit.
   assign step    = acc + (mplier[0] ? mcand : '0);
   assign done    = busy && (cnt == CW'(WIDTH - 1));
   assign product = step;

   // Operand load on start, then one shift-add step per cycle while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// are registered on the accepting edge; MUL runs through the iterative
// multiplier. The result and its flags are held until the consumer takes it.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [WIDTH-1:0] Out,
   output logic [2:0]       Nzp,
   output logic             C,
   output logic             V,
   output logic             Err
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   alu_state_t       state;
   alu_state_t       state_nxt;
   alu_flags_t       flags;
   alu_flags_t       flags_nxt;

   logic             accept;
   logic             is_mul;
   logic             load_alu;
   logic             load_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic [SHW-1:0]   sh_amt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_err;
   logic [WIDTH-1:0] res_nxt;

   // Handshake qualifiers.
   assign In_ready  = (state == IDLE) || ((state == HOLD) && Out_ready);
   assign Out_valid = (state == HOLD);
   assign accept    = In_valid && In_ready;
   assign is_mul    = (Op == OP_MUL);
   assign load_alu  = accept && !is_mul;
   assign load_mul  = (state == MUL) && mul_done;

   // Upper bits of B are ignored for shifts.
   assign sh_amt = B[SHW-1:0];
   assign sum    = {1'b0, A} + {1'b0, B};
   assign diff   = {1'b0, A} - {1'b0, B};

   // Single-cycle operation decode; unlisted codes take the illegal path.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (Op)
         OP_PASS: alu_res = A;
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
         end
         OP_AND:  alu_res = A & B;
         OP_NOT:  alu_res = ~A;
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = ~diff[WIDTH];
            alu_v   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
         end
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_SHL:  alu_res = A << sh_amt;
         OP_SHR:  alu_res = A >> sh_amt;
         OP_SRA:  alu_res = $signed(A) >>> sh_amt;
         OP_MUL:  alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   // Select the value to register and derive its flags.
   always_comb begin
      res_nxt   = load_mul ? mul_product : alu_res;
      flags_nxt = FLAGS_RESET;
      flags_nxt.n   = res_nxt[MSB];
      flags_nxt.z   = (res_nxt == '0);
      flags_nxt.p   = !res_nxt[MSB] && (res_nxt != '0);
      flags_nxt.c   = load_mul ? 1'b0 : alu_c;
      flags_nxt.v   = load_mul ? 1'b0 : alu_v;
      flags_nxt.err = load_mul ? 1'b0 : alu_err;
   end

   // Controller next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = is_mul ? MUL : HOLD;
            end
         end
         MUL: begin
            if (mul_done) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (Out_ready) begin
               if (accept) begin
                  state_nxt = is_mul ? MUL : HOLD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Result and flag registers; loaded only when a result completes.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Out   <= '0;
         flags <= FLAGS_RESET;
      end else if (load_alu || load_mul) begin
         Out   <= res_nxt;
         flags <= flags_nxt;
      end
   end

   assign Nzp = {flags.n, flags.z, flags.p};
   assign C   = flags.c;
   assign V   = flags.v;
   assign Err = flags.err;

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .start   (accept && is_mul),
      .a       (A),
      .b       (B),
      .done    (mul_done),
      .product (mul_product)
   );

endmodule
